// File: rtl/min_queue_pkg.sv
// Shared types and constants for the min-queue driver and queue.
// Record layout: key in the upper bits, payload below.
package min_queue_pkg;

    localparam int REC_W   = 48;
    localparam int KEY_MSB = 47;
    localparam int KEY_LSB = 32;
    localparam int KEY_W   = KEY_MSB - KEY_LSB + 1;
    localparam int Q_DEPTH = 1024;
    localparam int CNT_W   = 11;

    typedef logic [REC_W-1:0] rec_t;
    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } drv_state_t;

    function automatic key_t rec_key(input rec_t r);
        return r[KEY_MSB:KEY_LSB];
    endfunction

endpackage

// File: rtl/key_order_chk.sv
// Checks that popped keys come out non-decreasing within a batch.
// The first pop of each batch only seeds the previous key.
module key_order_chk
    import min_queue_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic batch_start,
    input  logic pop,
    input  key_t key,
    output logic order_err
);

    key_t prev_key;
    logic first;

    // Track previous key and raise a sticky error on a decrease
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            prev_key  <= '0;
            first     <= 1'b1;
            order_err <= 1'b0;
        end else begin
            if (pop) begin
                prev_key <= key;
                first    <= 1'b0;
                if (!first && (key < prev_key))
                    order_err <= 1'b1;
            end else if (batch_start) begin
                first <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/min_queue_drv.sv
// Batch sorter driver: fills a min-queue from an upstream stream,
// then drains it in key order to a registered downstream stream.
module min_queue_drv
    import min_queue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REC_W-1:0] in_record,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_record,
    output logic             out_last,
    output logic             q_push,
    output logic [REC_W-1:0] q_push_record,
    input  logic             q_full,
    input  logic             q_push_wait,
    output logic             q_pop,
    input  logic [REC_W-1:0] q_pop_record,
    input  logic             q_empty,
    input  logic             q_min_valid,
    output logic             busy,
    output logic             order_err,
    output logic [CNT_W-1:0] batch_cnt
);

    drv_state_t       state;
    logic [CNT_W-1:0] rem;
    logic             holdoff;
    logic             accept;
    logic             batch_start;
    logic             out_fire;
    key_t             pop_key;

    assign in_ready = (state == FILL) && !q_full && !q_push_wait
                      && (batch_cnt < CNT_W'(Q_DEPTH));
    assign accept        = in_valid && in_ready;
    assign batch_start   = accept && in_last;
    assign q_push        = accept;
    assign q_push_record = in_record;

    // holdoff hides the queue's min_valid for the cycle after a pop,
    // when it still reflects the pre-pop contents
    assign q_pop = (state == DRAIN) && q_min_valid && !q_empty
                   && (rem != '0) && !holdoff
                   && (!out_valid || out_ready);

    assign out_fire = out_valid && out_ready;
    assign busy     = (state == DRAIN);
    assign pop_key  = rec_key(q_pop_record);

    // Fill/drain sequencing with registered downstream outputs
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state      <= FILL;
            batch_cnt  <= '0;
            rem        <= '0;
            holdoff    <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_record <= '0;
        end else begin
            holdoff <= q_pop;
            unique case (state)
                FILL: begin
                    if (accept) begin
                        batch_cnt <= batch_cnt + 1'b1;
                        if (in_last) begin
                            state <= DRAIN;
                            rem   <= batch_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (q_pop) begin
                        out_record <= q_pop_record;
                        out_valid  <= 1'b1;
                        out_last   <= (rem == CNT_W'(1));
                        rem        <= rem - 1'b1;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last && (rem == '0)) begin
                            state     <= FILL;
                            batch_cnt <= '0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    key_order_chk u_chk (
        .clk         (clk),
        .rst_b       (rst_b),
        .batch_start (batch_start),
        .pop         (q_pop),
        .key         (pop_key),
        .order_err   (order_err)
    );

endmodule

// File: tb/tb_min_queue_drv.sv
// Bench for min_queue_drv with a behavioural min-queue model
// and a scoreboard on the downstream stream.
module tb_min_queue_drv;
    import min_queue_pkg::*;

    logic             clk = 1'b0;
    logic             rst_b = 1'b1;
    logic             in_valid, in_ready, in_last;
    logic [REC_W-1:0] in_record;
    logic             out_valid, out_ready, out_last;
    logic [REC_W-1:0] out_record;
    logic             q_push, q_full, q_push_wait;
    logic [REC_W-1:0] q_push_record;
    logic             q_pop, q_empty, q_min_valid;
    logic [REC_W-1:0] q_pop_record;
    logic             busy, order_err;
    logic [CNT_W-1:0] batch_cnt;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    logic exp_last_q[$];
    rec_t sb_r;
    logic sb_l;
    bit   fifo_mode = 1'b0;
    int   pop_cnt = 0;
    rec_t mq[$];

    localparam rec_t R5  = {16'h0005, 32'h0000_00A0};
    localparam rec_t R1  = {16'h0001, 32'h0000_00A1};
    localparam rec_t R3  = {16'h0003, 32'h0000_00A2};
    localparam rec_t R7  = {16'h0007, 32'h0000_00B0};
    localparam rec_t R2  = {16'h0002, 32'h0000_00B1};
    localparam rec_t R9  = {16'h0009, 32'h0000_00B2};
    localparam rec_t R10 = {16'h0010, 32'h0000_00C0};
    localparam rec_t R0F = {16'h000F, 32'h0000_00C1};
    localparam rec_t RA  = {16'h000A, 32'h0000_00D0};
    localparam rec_t R4  = {16'h0004, 32'h0000_00D1};
    localparam rec_t RC  = {16'h000C, 32'h0000_00D2};

    min_queue_drv dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_record     (in_record),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_record    (out_record),
        .out_last      (out_last),
        .q_push        (q_push),
        .q_push_record (q_push_record),
        .q_full        (q_full),
        .q_push_wait   (q_push_wait),
        .q_pop         (q_pop),
        .q_pop_record  (q_pop_record),
        .q_empty       (q_empty),
        .q_min_valid   (q_min_valid),
        .busy          (busy),
        .order_err     (order_err),
        .batch_cnt     (batch_cnt)
    );

    always #5 clk = ~clk;

    function automatic int min_idx();
        int k;
        k = 0;
        if (!fifo_mode)
            for (int i = 1; i < mq.size(); i++)
                if (mq[i][KEY_MSB:KEY_LSB] < mq[k][KEY_MSB:KEY_LSB])
                    k = i;
        return k;
    endfunction

    // Queue model: registered min record, min_valid lags one cycle
    always @(posedge clk or posedge rst_b) begin : mdl
        bit pre;
        if (rst_b) begin
            mq.delete();
            pop_cnt = 0;
            q_pop_record <= '0;
            q_min_valid  <= 1'b0;
            q_empty      <= 1'b1;
        end else begin
            pre = (mq.size() != 0);
            if (q_pop && mq.size() != 0) begin
                mq.delete(min_idx());
                pop_cnt++;
            end
            if (q_push)
                mq.push_back(q_push_record);
            q_min_valid  <= pre;
            q_empty      <= (mq.size() == 0);
            q_pop_record <= (mq.size() != 0) ? mq[min_idx()] : '0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor on the downstream handshake
    always @(negedge clk) begin
        if (!rst_b && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none",
                         out_record);
            end else begin
                sb_r = exp_q.pop_front();
                sb_l = exp_last_q.pop_front();
                chk("sb_record", 64'(out_record), 64'(sb_r));
                chk("sb_last", 64'(out_last), 64'(sb_l));
            end
        end
    end

    task automatic push_exp(input rec_t r, input logic l);
        exp_q.push_back(r);
        exp_last_q.push_back(l);
    endtask

    task automatic send(input rec_t r, input logic last);
        int n;
        in_record = r;
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || out_valid) && n < 200);
        chk({nm, "_idle"}, 64'(busy || out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 20 && !out_valid; i++)
            @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int np;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_record   = '0;
        out_ready   = 1'b1;
        q_full      = 1'b0;
        q_push_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_record", 64'(out_record), 64'd0);
        chk("rst_batch_cnt", 64'(batch_cnt), 64'd0);
        chk("rst_order_err", 64'(order_err), 64'd0);
        chk("rst_q_pop", 64'(q_pop), 64'd0);
        @(posedge clk);
        #1;

        push_exp(R1, 1'b0);
        push_exp(R3, 1'b0);
        push_exp(R5, 1'b1);
        send(R5, 1'b0);
        send(R1, 1'b0);
        send(R3, 1'b1);
        @(negedge clk);
        chk("b1_busy_next", 64'(busy), 64'd1);
        wait_idle("b1");
        chk("b1_order_err", 64'(order_err), 64'd0);
        chk("b1_batch_cnt", 64'(batch_cnt), 64'd0);

        in_record = R7;
        in_valid  = 1'b1;
        q_full    = 1'b1;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        q_full      = 1'b0;
        q_push_wait = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pw_in_ready", 64'(in_ready), 64'd0);
            chk("pw_q_push", 64'(q_push), 64'd0);
            @(posedge clk);
            #1;
        end
        q_push_wait = 1'b0;
        @(negedge clk);
        chk("pw_resume", 64'(q_push), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pw_batch_cnt", 64'(batch_cnt), 64'd1);
        @(posedge clk);
        #1;

        push_exp(R2, 1'b0);
        push_exp(R7, 1'b0);
        push_exp(R9, 1'b1);
        out_ready = 1'b0;
        base = pop_cnt;
        send(R2, 1'b0);
        send(R9, 1'b1);
        wait_out_valid();
        chk("st_pops_before", 64'(pop_cnt - base), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("st_out_valid", 64'(out_valid), 64'd1);
            chk("st_out_record", 64'(out_record), 64'(R2));
            chk("st_q_pop", 64'(q_pop), 64'd0);
        end
        chk("st_pops_after", 64'(pop_cnt - base), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("b2");

        fifo_mode = 1'b1;
        push_exp(R10, 1'b0);
        push_exp(R0F, 1'b1);
        send(R10, 1'b0);
        send(R0F, 1'b1);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q_pop) begin
                np++;
                if (np == 2) begin
                    chk("oe_before", 64'(order_err), 64'd0);
                    @(negedge clk);
                    chk("oe_rise", 64'(order_err), 64'd1);
                    break;
                end
            end
        end
        chk("oe_pops", 64'(np), 64'd2);
        wait_idle("b3");
        fifo_mode = 1'b0;
        chk("oe_sticky", 64'(order_err), 64'd1);

        for (int i = 0; i < 1024; i++)
            send({16'(1023 - i), 32'(i)}, 1'b0);
        @(negedge clk);
        chk("cap_batch_cnt", 64'(batch_cnt), 64'd1024);
        @(posedge clk);
        #1;
        in_record = R4;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("cap_in_ready", 64'(in_ready), 64'd0);
            chk("cap_q_push", 64'(q_push), 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("cap_cnt_hold", 64'(batch_cnt), 64'd1024);
        chk("oe_sticky2", 64'(order_err), 64'd1);

        @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk("rst_fill_cnt", 64'(batch_cnt), 64'd0);
        @(posedge clk);
        #1 rst_b = 1'b0;

        out_ready = 1'b0;
        send(RA, 1'b0);
        send(R4, 1'b0);
        send(RC, 1'b1);
        wait_out_valid();
        chk("md_in_drain", 64'(busy && out_valid), 64'd1);
        #2 rst_b = 1'b1;
        #1;
        chk("md_out_valid", 64'(out_valid), 64'd0);
        chk("md_busy", 64'(busy), 64'd0);
        chk("md_q_pop", 64'(q_pop), 64'd0);
        chk("md_batch_cnt", 64'(batch_cnt), 64'd0);
        chk("md_order_err", 64'(order_err), 64'd0);
        exp_q.delete();
        exp_last_q.delete();
        @(posedge clk);
        #1;
        rst_b     = 1'b0;
        out_ready = 1'b1;

        push_exp(R4, 1'b0);
        push_exp(RA, 1'b1);
        send(RA, 1'b0);
        send(R4, 1'b1);
        wait_idle("b5");
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("b5_order_err", 64'(order_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
